// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared DATA_W-bit register.
// Optional lock timeout enabled by defining SHARED_REG_LOCK_TIMEOUT_EN.
module shared_reg_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic                       clock,
   input  logic                       clear,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         lock,
   input  logic [NUM_REQ*DATA_W-1:0]  wr_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic [DATA_W-1:0]          q,
   output logic                       busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_LOCKED
   } state_t;

   if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 1) begin : g_param_err
      $error("shared_reg_arbiter: unsupported NUM_REQ or LOCK_MAX");
   end

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                busy_q, busy_d;

   logic [IDX_W-1:0]    ptr_adv;
   logic [IDX_W-1:0]    scan_base;
   logic [DATA_W-1:0]   owner_data;
   logic                own_req;
   logic                own_lock;
   logic                win_vld;
   logic [IDX_W-1:0]    win_idx;
   int                  scan_i;
   logic                rescan;
   logic                timeout;

`ifdef SHARED_REG_LOCK_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(LOCK_MAX) + 1;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   assign timeout = (cnt_q == CNT_W'(LOCK_MAX - 1));
`else
   assign timeout = 1'b0;
`endif

   // Pointer position just past the current owner, wrapping at NUM_REQ.
   assign ptr_adv   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
   // The end-of-GRANT scan must already see the advanced pointer.
   assign scan_base = (state_q == ST_GRANT) ? ptr_adv : ptr_q;

   // Owner's data, request and lock bits.
   always_comb begin
      owner_data = '0;
      own_req    = 1'b0;
      own_lock   = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (owner_q == IDX_W'(i)) begin
            owner_data = wr_data[i*DATA_W +: DATA_W];
            own_req    = req[i];
            own_lock   = lock[i];
         end
      end
   end

   // Rotating priority scan; scanning downward leaves the nearest requester as winner.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      scan_i  = 0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         scan_i = (int'(scan_base) + k) % int'(NUM_REQ);
         if (req[scan_i]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(scan_i);
         end
      end
   end

   // Next-state, write and grant decisions.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      data_d  = data_q;
      ptr_d   = ptr_q;
      rescan  = 1'b0;

      case (state_q)
         ST_IDLE: rescan = 1'b1;
         ST_GRANT: begin
            data_d = owner_data;
            ptr_d  = ptr_adv;
            if (own_lock) state_d = ST_LOCKED;
            else          rescan  = 1'b1;
         end
         ST_LOCKED: begin
            if (!own_lock) begin
               rescan = 1'b1;
            end else begin
               if (own_req) data_d = owner_data;
               if (timeout) rescan = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase

      if (rescan) begin
         if (win_vld) begin
            state_d = ST_GRANT;
            owner_d = win_idx;
            gnt_d   = NUM_REQ'(1) << win_idx;
         end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      end

`ifdef SHARED_REG_LOCK_TIMEOUT_EN
      cnt_d = ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) ? cnt_q + CNT_W'(1) : '0;
`endif
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
`ifdef SHARED_REG_LOCK_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
`ifdef SHARED_REG_LOCK_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign q     = data_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Testbench for shared_reg_arbiter: directed scenarios plus random traffic against a reference model.
module tb_shared_reg_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int LM = 4;

   logic           clock = 1'b0;
   logic           clear;
   logic [N-1:0]   req;
   logic [N-1:0]   lock;
   logic [N*W-1:0] wr_data;
   logic [N-1:0]   gnt;
   logic [1:0]     owner;
   logic [W-1:0]   q;
   logic           busy;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: 0 = idle, 1 = granted (single cycle), 2 = locked.
   int m_mode, m_owner, m_ptr, m_q, m_locked_cycles;

   always #5 clock = ~clock;

   shared_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .LOCK_MAX(LM)) dut (
      .clock   (clock),
      .clear   (clear),
      .req     (req),
      .lock    (lock),
      .wr_data (wr_data),
      .gnt     (gnt),
      .owner   (owner),
      .q       (q),
      .busy    (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int data_of(input int i);
      return int'(wr_data[i*W +: W]);
   endfunction

   // First requester found walking forward from base, or -1.
   function automatic int first_from(input int base);
      for (int k = 0; k < N; k++) begin
         if (req[(base + k) % N]) return (base + k) % N;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_owner = 0; m_ptr = 0; m_q = 0; m_locked_cycles = 0;
   endfunction

   function automatic void model_hand_over();
      int w;
      w = first_from(m_ptr);
      m_locked_cycles = 0;
      if (w >= 0) begin
         m_mode  = 1;
         m_owner = w;
      end else begin
         m_mode = 0;
      end
   endfunction

   function automatic void model_step();
      case (m_mode)
         0: model_hand_over();
         1: begin
            m_q   = data_of(m_owner);
            m_ptr = (m_owner + 1) % N;
            if (lock[m_owner]) begin
               m_mode = 2;
               m_locked_cycles = 0;
            end else begin
               model_hand_over();
            end
         end
         default: begin
            if (!lock[m_owner]) begin
               model_hand_over();
            end else begin
               if (req[m_owner]) m_q = data_of(m_owner);
               m_locked_cycles++;
`ifdef SHARED_REG_LOCK_TIMEOUT_EN
               if (m_locked_cycles == LM) model_hand_over();
`endif
            end
         end
      endcase
   endfunction

   task automatic compare_all();
      check("gnt", 32'(gnt), (m_mode != 0) ? (32'd1 << m_owner) : 32'd0);
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("q", 32'(q), 32'(m_q));
      if (m_mode != 0) check("owner", 32'(owner), 32'(m_owner));
   endtask

   // One clock edge: advance the model with the inputs in force, then compare.
   task automatic tick();
      @(posedge clock);
      if (clear) model_reset();
      else       model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic set_data(input int i, input logic [W-1:0] v);
      wr_data[i*W +: W] = v;
   endtask

   task automatic async_clear();
      clear = 1'b1;
      #2;
      model_reset();
      compare_all();
      tick();
      clear = 1'b0;
   endtask

   logic [N-1:0] exp_gnt;

   initial begin
      model_reset();
      clear = 1'b1; req = '0; lock = '0; wr_data = '0;
      tick();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_q", 32'(q), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      clear = 1'b0;

      // Reset while locked
      req = 4'b0010; lock = 4'b0010; set_data(1, 8'h5A);
      tick();
      req = '0;
      tick();
      tick();
      check("midlock_q_before", 32'(q), 32'h5A);
      clear = 1'b1;
      #2;
      model_reset();
      check("midlock_gnt", 32'(gnt), 32'd0);
      check("midlock_q", 32'(q), 32'd0);
      check("midlock_busy", 32'(busy), 32'd0);
      tick();
      clear = 1'b0; lock = '0; req = 4'b1000;
      tick();
      check("after_clear_gnt", 32'(gnt), 32'b1000);
      req = '0;
      tick();

      // Single write
      do_reset();
      req = 4'b0100; set_data(2, 8'hA5);
      tick();
      check("single_gnt", 32'(gnt), 32'b0100);
      req = '0;
      tick();
      check("single_q", 32'(q), 32'hA5);
      check("single_idle", 32'(gnt), 32'd0);

      // Round-robin fairness
      do_reset();
      for (int i = 0; i < N; i++) set_data(i, W'(8'h10 * (i + 1) + i));
      req = 4'b1111; lock = '0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_gnt", 32'(gnt), 32'd1 << (k % N));
         if (k > 0) check("rr_q", 32'(q), 32'(8'h10 * (((k - 1) % N) + 1) + ((k - 1) % N)));
      end
      req = '0;
      tick();
      tick();

      // Lock burst with a competing requester
      do_reset();
      req = 4'b1001; lock = 4'b0001; set_data(0, 8'h11); set_data(3, 8'hEE);
      tick();
      tick();
      check("burst_q1", 32'(q), 32'h11);
      set_data(0, 8'h22);
      tick();
      check("burst_q2", 32'(q), 32'h22);
      set_data(0, 8'h33);
      tick();
      check("burst_q3", 32'(q), 32'h33);
      check("burst_hold", 32'(gnt), 32'b0001);
      lock = '0; req = 4'b1000;
      tick();
      check("burst_release", 32'(gnt), 32'b1000);
      req = '0;
      tick();
      tick();

      // Lock without request
      do_reset();
      req = 4'b0010; lock = 4'b0010; set_data(1, 8'h44);
      tick();
      req = '0;
      tick();
      for (int j = 0; j < 3; j++) begin
         set_data(1, W'($urandom));
         tick();
         check("lock_noreq_q", 32'(q), 32'h44);
      end
      req = 4'b0010; set_data(1, 8'h7E);
      tick();
      check("lock_req_q", 32'(q), 32'h7E);
      req = '0; lock = '0;
      tick();
      tick();

      // Lock timeout
      do_reset();
      req = 4'b0100; lock = 4'b0100; set_data(2, 8'hC3); set_data(0, 8'h0F);
      tick();
      req = 4'b0101;
      tick();
      for (int j = 0; j < LM; j++) begin
         set_data(2, W'(8'hC4 + j));
         tick();
      end
`ifdef SHARED_REG_LOCK_TIMEOUT_EN
      exp_gnt = 4'b0001;
`else
      exp_gnt = 4'b0100;
`endif
      check("timeout_gnt", 32'(gnt), 32'(exp_gnt));
      check("timeout_q", 32'(q), 32'(8'hC4 + LM - 1));
      req = '0; lock = '0;
      tick();
      tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         req     = N'($urandom);
         wr_data = (N*W)'($urandom);
         if (c % 8 == 0) lock = N'($urandom);
         if ($urandom_range(0, 199) == 0) async_clear();
         else                              tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared DATA_W-bit register built from clocked flip-flops with clear.
- Up to NUM_REQ requesters compete for the register's write port.
- A requester may lock ownership to perform several consecutive writes.
- Sits between producer blocks and the shared storage flops. It is the only block that drives the register's d input and write enable.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of the shared register.
- LOCK_MAX, 16, maximum LOCKED cycles per ownership (used only with the optional feature).

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset.
- req  input  NUM_REQ  level write request, one bit per requester.
- lock  input  NUM_REQ  per-requester request to keep ownership after its grant.
- wr_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  registered one-hot grant; all zeros when idle.
- owner  output  clog2(NUM_REQ)  index of the current grantee; valid while gnt is nonzero.
- q  output  DATA_W  shared register contents.
- busy  output  1  high in GRANT or LOCKED.

Behaviour:
- Reset (clear high, asynchronous):
  - state=IDLE, gnt=0, owner=0, q=0, busy=0, rr pointer ptr=0.
  - Takes effect immediately, including mid-GRANT or mid-LOCKED.
  - No write occurs on the edge where clear is high.
- Winner selection: first i with req[i]=1, scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
- IDLE:
  - If any req is high, next state is GRANT, gnt<=onehot(winner), owner<=winner.
  - Otherwise stay in IDLE.
- GRANT (exactly one cycle with gnt high). At the edge ending GRANT:
  - q<=wr_data[owner]; the write is unconditional.
  - ptr<=(owner+1) mod NUM_REQ.
  - If lock[owner]=1, go to LOCKED with gnt held.
  - Otherwise, if any req is high, go back to GRANT with a new winner chosen using the updated ptr. This gives back-to-back grants with no idle bubble.
  - Otherwise go to IDLE with gnt<=0.
- LOCKED (gnt and owner held). At each edge:
  - If lock[owner]=0: release. Then, if any req (including owner) is high, go to GRANT with a new winner from ptr; otherwise go to IDLE.
  - Else if req[owner]=1: q<=wr_data[owner] and stay in LOCKED.
  - Else: hold q and stay in LOCKED.
  - Requests from other requesters are ignored while LOCKED.
- Latency:
  - req rising before edge E gives gnt high after E.
  - q is updated at E+1.
  - Minimum request-to-q latency is 2 edges.
- Requesters must drop req in the cycle after seeing their gnt bit. A req still high at the end of GRANT counts as a new request at the lowest rotated priority.
- Simultaneous requests: exactly one gnt bit is ever high. Fairness: with all NUM_REQ requesting continuously and none locking, grants rotate 0,1,2,…,NUM_REQ-1,0.
- A lock bit is only meaningful for the current owner; lock bits of other requesters are ignored.
- busy=1 exactly when gnt is nonzero.
- wr_data of non-owners never affects q.

Optional Feature:
- Macro: SHARED_REG_LOCK_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to LOCKED and increments each LOCKED cycle.
  - When it reaches LOCK_MAX-1 with lock still high, the owner is forcibly released on the next edge. The next state follows the normal release rule, with ptr already advanced past the owner.
  - The write on that final edge still occurs if req[owner]=1.
  - The counter resets to 0 on clear and on every release.
- Undefined: no counter is present, and LOCKED persists indefinitely while lock[owner]=1.

Test Plan:
- Reset mid-lock: requester 1 in LOCKED with q=0x5A; raise clear asynchronously between edges -> gnt=0, q=0x00, busy=0 immediately. After clear drops, req[3]=1 -> gnt=4'b1000.
- Single write: after reset, req[2]=1 with wr_data[2]=0xA5 for one cycle before edge 1 -> gnt=4'b0100 after edge 1, q=0xA5 after edge 2, back to IDLE.
- Round-robin fairness: req=4'b1111 held, lock=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles with no idle gaps. Each q equals the granted requester's data.
- Lock burst: requester 0 locks with req[0]=1 and data 0x11,0x22,0x33 while req[3]=1 -> q takes 0x11,0x22,0x33 on successive edges. gnt[3] stays 0 until lock[0] drops, then gnt=4'b1000 the next cycle.
- Lock without req: requester 1 in LOCKED with req[1]=0 for 3 cycles -> q unchanged. Then req[1]=1 with data 0x7E -> q=0x7E on the next edge.
- Timeout (macro defined, LOCK_MAX=4): requester 2 holds lock=1 and req=1 -> exactly 4 LOCKED cycles, then forced release. With req[0]=1 pending -> gnt=4'b0001.
